// File: rtl/memory_cycle_pkg.sv
// Shared definitions for the memory stage: wait-FSM encoding, address
// alignment mask and default watchdog sizing.
package memory_cycle_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } wait_state_e;

  localparam logic [31:0] WORD_ALIGN_MASK        = 32'hFFFF_FFFC;
  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 255;
  localparam int unsigned DEFAULT_CNT_W          = 8;

endpackage

// File: rtl/memory_cycle_if.sv
// Valid/ready data-memory bus between the memory stage (master) and the
// data memory (slave).
interface memory_cycle_if;

  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ready, mem_rdata
  );

endinterface

// File: rtl/mem_wait_ctrl.sv
// Wait-state controller: tracks an outstanding access, runs the timeout
// watchdog and produces the request valid and the pipeline stall.
//
// state   | meaning
// IDLE    | no access outstanding, counter = 0
// WAIT    | request issued, mem_ready not yet seen
module mem_wait_ctrl
  import memory_cycle_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int unsigned CNT_W          = DEFAULT_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic access_i,
  input  logic misaligned_i,
  input  logic mem_ready_i,
  output logic mem_req_o,
  output logic stall_o,
  output logic timeout_hit_o
);

  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  wait_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    timeout_hit_o = (state_q == ST_WAIT) && (cnt_q == TIMEOUT_VAL);
    // The watchdog hit withdraws the request so the access retires as aborted.
    mem_req_o     = access_i & ~misaligned_i & ~timeout_hit_o;
    stall_o       = mem_req_o & ~mem_ready_i;

    case (state_q)
      ST_IDLE: begin
        if (stall_o) begin
          state_d = ST_WAIT;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = '0;
        end
      end
      ST_WAIT: begin
        if (stall_o) begin
          if (cnt_q != TIMEOUT_VAL) cnt_d = cnt_q + CNT_ONE;
        end else begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: rtl/memory_cycle.sv
// Memory pipeline stage: issues loads/stores on the data-memory bus, stalls
// upstream while an access is outstanding and registers the M/W stage.
module memory_cycle
  import memory_cycle_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int unsigned CNT_W          = DEFAULT_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 RegWriteM,
  input  logic                 MemWriteM,
  input  logic                 ResultSrcM,
  input  logic [4:0]           RD_M,
  input  logic [31:0]          PCPlus4M,
  input  logic [31:0]          WriteDataM,
  input  logic [31:0]          ALU_ResultM,
  memory_cycle_if.master       mem,
  output logic                 StallM,
  output logic                 RegWriteW,
  output logic                 ResultSrcW,
  output logic [4:0]           RD_W,
  output logic [31:0]          PCPlus4W,
  output logic [31:0]          ALU_ResultW,
  output logic [31:0]          ReadDataW,
  output logic                 ErrW
);

  logic access;
  logic misaligned;
  logic mem_req;
  logic timeout_hit;
  logic abort;
  logic load_done;

  assign access     = MemWriteM | ResultSrcM;
  assign misaligned = access & (|(ALU_ResultM & ~WORD_ALIGN_MASK));

  mem_wait_ctrl #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_W          (CNT_W)
  ) u_wait_ctrl (
    .clk           (clk),
    .rst           (rst),
    .access_i      (access),
    .misaligned_i  (misaligned),
    .mem_ready_i   (mem.mem_ready),
    .mem_req_o     (mem_req),
    .stall_o       (StallM),
    .timeout_hit_o (timeout_hit)
  );

  assign mem.mem_req   = mem_req;
  assign mem.mem_we    = MemWriteM;
  assign mem.mem_addr  = ALU_ResultM & WORD_ALIGN_MASK;
  assign mem.mem_wdata = WriteDataM;

  assign abort     = access & (misaligned | timeout_hit);
  assign load_done = mem_req & mem.mem_ready & ResultSrcM & ~MemWriteM;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      RegWriteW   <= 1'b0;
      ResultSrcW  <= 1'b0;
      RD_W        <= '0;
      PCPlus4W    <= '0;
      ALU_ResultW <= '0;
      ReadDataW   <= '0;
      ErrW        <= 1'b0;
    end else if (StallM) begin
      // Bubble: control bits cleared, data fields hold.
      RegWriteW  <= 1'b0;
      ResultSrcW <= 1'b0;
      ErrW       <= 1'b0;
    end else begin
      RegWriteW   <= RegWriteM & ~abort;
      ResultSrcW  <= ResultSrcM;
      RD_W        <= RD_M;
      PCPlus4W    <= PCPlus4M;
      ALU_ResultW <= ALU_ResultM;
      ReadDataW   <= load_done ? mem.mem_rdata : '0;
      ErrW        <= abort;
    end
  end

endmodule

// File: tb/tb_memory_cycle.sv
// Directed self-checking bench for the memory pipeline stage.
module tb_memory_cycle;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWriteM, MemWriteM, ResultSrcM;
  logic [4:0]  RD_M;
  logic [31:0] PCPlus4M, WriteDataM, ALU_ResultM;
  logic        StallM, RegWriteW, ResultSrcW, ErrW;
  logic [4:0]  RD_W;
  logic [31:0] PCPlus4W, ALU_ResultW, ReadDataW;

  int checks = 0;
  int errors = 0;

  memory_cycle_if mem_bus ();

  memory_cycle #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .RegWriteM   (RegWriteM),
    .MemWriteM   (MemWriteM),
    .ResultSrcM  (ResultSrcM),
    .RD_M        (RD_M),
    .PCPlus4M    (PCPlus4M),
    .WriteDataM  (WriteDataM),
    .ALU_ResultM (ALU_ResultM),
    .mem         (mem_bus.master),
    .StallM      (StallM),
    .RegWriteW   (RegWriteW),
    .ResultSrcW  (ResultSrcW),
    .RD_W        (RD_W),
    .PCPlus4W    (PCPlus4W),
    .ALU_ResultW (ALU_ResultW),
    .ReadDataW   (ReadDataW),
    .ErrW        (ErrW)
  );

  always #5 clk = ~clk;

  task automatic drive_idle();
    RegWriteM = 0; MemWriteM = 0; ResultSrcM = 0;
    RD_M = 0; PCPlus4M = 0; WriteDataM = 0; ALU_ResultM = 0;
    mem_bus.mem_ready = 0; mem_bus.mem_rdata = 0;
  endtask

  task automatic test_reset();
    rst = 0;
    drive_idle();
    ALU_ResultM = 32'h1234_5677; ResultSrcM = 1; mem_bus.mem_ready = 1;
    #1;
    checks++; if ({RegWriteW, ResultSrcW, ErrW} !== 3'b000) begin errors++; $display("FAIL reset_ctrl got %b want 000", {RegWriteW, ResultSrcW, ErrW}); end
    checks++; if ({RD_W, PCPlus4W, ALU_ResultW, ReadDataW} !== '0) begin errors++; $display("FAIL reset_data got %h want 0", {RD_W, PCPlus4W, ALU_ResultW, ReadDataW}); end
    checks++; if (mem_bus.mem_addr !== 32'h1234_5674) begin errors++; $display("FAIL reset_addr_comb got %h want 12345674", mem_bus.mem_addr); end
    checks++; if (mem_bus.mem_req !== 1'b0 || StallM !== 1'b0) begin errors++; $display("FAIL reset_misaligned_req got req=%b stall=%b want 0 0", mem_bus.mem_req, StallM); end
    @(negedge clk); drive_idle(); rst = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_zero_wait_load();
    @(negedge clk);
    drive_idle();
    ALU_ResultM = 32'h100; ResultSrcM = 1; RegWriteM = 1; RD_M = 5; PCPlus4M = 32'h44;
    mem_bus.mem_ready = 1; mem_bus.mem_rdata = 32'hDEAD_BEEF;
    #1;
    checks++; if (StallM !== 1'b0) begin errors++; $display("FAIL zw_stall got %b want 0", StallM); end
    checks++; if (mem_bus.mem_req !== 1'b1 || mem_bus.mem_we !== 1'b0 || mem_bus.mem_addr !== 32'h100) begin errors++; $display("FAIL zw_req got req=%b we=%b addr=%h want 1 0 100", mem_bus.mem_req, mem_bus.mem_we, mem_bus.mem_addr); end
    @(posedge clk); #1;
    checks++; if (ReadDataW !== 32'hDEAD_BEEF) begin errors++; $display("FAIL zw_rdata got %h want deadbeef", ReadDataW); end
    checks++; if (RD_W !== 5'd5 || RegWriteW !== 1'b1 || ErrW !== 1'b0 || PCPlus4W !== 32'h44) begin errors++; $display("FAIL zw_wreg got rd=%0d rw=%b err=%b pc4=%h want 5 1 0 44", RD_W, RegWriteW, ErrW, PCPlus4W); end
  endtask

  task automatic test_store_wait();
    @(negedge clk);
    drive_idle();
    MemWriteM = 1; ALU_ResultM = 32'h204; WriteDataM = 32'h1234_5678; PCPlus4M = 32'h48; RD_M = 2;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (StallM !== 1'b1) begin errors++; $display("FAIL st_stall[%0d] got %b want 1", i, StallM); end
      checks++; if (mem_bus.mem_addr !== 32'h204 || mem_bus.mem_wdata !== 32'h1234_5678 || mem_bus.mem_we !== 1'b1) begin errors++; $display("FAIL st_bus[%0d] got addr=%h wdata=%h we=%b", i, mem_bus.mem_addr, mem_bus.mem_wdata, mem_bus.mem_we); end
      @(posedge clk); #1;
      checks++; if (RegWriteW !== 1'b0 || ALU_ResultW !== 32'h100 || ReadDataW !== 32'hDEAD_BEEF) begin errors++; $display("FAIL st_bubble[%0d] got rw=%b alu=%h rdata=%h want 0 100 deadbeef", i, RegWriteW, ALU_ResultW, ReadDataW); end
      @(negedge clk);
    end
    mem_bus.mem_ready = 1;
    #1;
    checks++; if (StallM !== 1'b0) begin errors++; $display("FAIL st_done_stall got %b want 0", StallM); end
    @(posedge clk); #1;
    checks++; if (ALU_ResultW !== 32'h204 || ReadDataW !== 32'h0 || ErrW !== 1'b0 || RD_W !== 5'd2) begin errors++; $display("FAIL st_wreg got alu=%h rdata=%h err=%b rd=%0d want 204 0 0 2", ALU_ResultW, ReadDataW, ErrW, RD_W); end
  endtask

  task automatic test_misaligned();
    @(negedge clk);
    drive_idle();
    ALU_ResultM = 32'h102; ResultSrcM = 1; RegWriteM = 1; RD_M = 7;
    mem_bus.mem_ready = 1; mem_bus.mem_rdata = 32'hCAFE_F00D;
    #1;
    checks++; if (mem_bus.mem_req !== 1'b0 || StallM !== 1'b0) begin errors++; $display("FAIL mis_req got req=%b stall=%b want 0 0", mem_bus.mem_req, StallM); end
    @(posedge clk); #1;
    checks++; if (ErrW !== 1'b1 || RegWriteW !== 1'b0 || ReadDataW !== 32'h0) begin errors++; $display("FAIL mis_abort got err=%b rw=%b rdata=%h want 1 0 0", ErrW, RegWriteW, ReadDataW); end
    checks++; if (ALU_ResultW !== 32'h102 || RD_W !== 5'd7) begin errors++; $display("FAIL mis_fields got alu=%h rd=%0d want 102 7", ALU_ResultW, RD_W); end
    @(negedge clk); drive_idle();
    @(posedge clk); #1;
    checks++; if (ErrW !== 1'b0) begin errors++; $display("FAIL mis_err_pulse got %b want 0", ErrW); end
  endtask

  task automatic test_timeout(input logic [31:0] addr, input logic [4:0] rd);
    @(negedge clk);
    drive_idle();
    ALU_ResultM = addr; ResultSrcM = 1; RegWriteM = 1; RD_M = rd;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (StallM !== 1'b1) begin errors++; $display("FAIL to_stall[%0d] got %b want 1", i, StallM); end
      @(posedge clk); #1;
      checks++; if (RegWriteW !== 1'b0 || ResultSrcW !== 1'b0 || ErrW !== 1'b0) begin errors++; $display("FAIL to_bubble[%0d] got rw=%b rs=%b err=%b want 0 0 0", i, RegWriteW, ResultSrcW, ErrW); end
      @(negedge clk);
    end
    #1;
    checks++; if (StallM !== 1'b0 || mem_bus.mem_req !== 1'b0) begin errors++; $display("FAIL to_hit got stall=%b req=%b want 0 0", StallM, mem_bus.mem_req); end
    @(posedge clk); #1;
    checks++; if (ErrW !== 1'b1 || RegWriteW !== 1'b0 || ResultSrcW !== 1'b1 || RD_W !== rd || ReadDataW !== 32'h0) begin errors++; $display("FAIL to_abort got err=%b rw=%b rs=%b rd=%0d rdata=%h", ErrW, RegWriteW, ResultSrcW, RD_W, ReadDataW); end
    @(negedge clk);
    drive_idle();
    ALU_ResultM = addr + 32'h10; ResultSrcM = 1; RegWriteM = 1; RD_M = rd + 5'd1;
    mem_bus.mem_rdata = 32'h0BAD_F00D;
    #1;
    checks++; if (StallM !== 1'b1) begin errors++; $display("FAIL to_next_stall got %b want 1", StallM); end
    @(posedge clk); #1;
    checks++; if (ErrW !== 1'b0) begin errors++; $display("FAIL to_err_pulse got %b want 0", ErrW); end
    @(negedge clk);
    mem_bus.mem_ready = 1;
    #1;
    checks++; if (StallM !== 1'b0) begin errors++; $display("FAIL to_next_ready got %b want 0", StallM); end
    @(posedge clk); #1;
    checks++; if (ReadDataW !== 32'h0BAD_F00D || RegWriteW !== 1'b1 || ErrW !== 1'b0 || ALU_ResultW !== addr + 32'h10) begin errors++; $display("FAIL to_next_load got rdata=%h rw=%b err=%b alu=%h", ReadDataW, RegWriteW, ErrW, ALU_ResultW); end
  endtask

  task automatic test_reset_mid_wait();
    @(negedge clk);
    drive_idle();
    MemWriteM = 1; ALU_ResultM = 32'h400; WriteDataM = 32'h5555_AAAA;
    #1;
    checks++; if (StallM !== 1'b1) begin errors++; $display("FAIL rmw_stall1 got %b want 1", StallM); end
    @(negedge clk); #1;
    checks++; if (StallM !== 1'b1) begin errors++; $display("FAIL rmw_stall2 got %b want 1", StallM); end
    #2;
    rst = 0;
    drive_idle();
    #1;
    checks++; if ({RegWriteW, ResultSrcW, ErrW} !== 3'b000 || {RD_W, PCPlus4W, ALU_ResultW, ReadDataW} !== '0) begin errors++; $display("FAIL rmw_async got alu=%h rd=%0d rdata=%h want all 0", ALU_ResultW, RD_W, ReadDataW); end
    @(negedge clk); rst = 1;
    @(posedge clk); #1;
    checks++; if (ErrW !== 1'b0 || RegWriteW !== 1'b0 || StallM !== 1'b0) begin errors++; $display("FAIL rmw_release got err=%b rw=%b stall=%b want 0 0 0", ErrW, RegWriteW, StallM); end
    test_timeout(32'h600, 5'd12);
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    drive_idle();
    ALU_ResultM = 32'h500; ResultSrcM = 1; RegWriteM = 1; RD_M = 3;
    mem_bus.mem_ready = 1; mem_bus.mem_rdata = 32'hA5A5_0001;
    #1;
    checks++; if (StallM !== 1'b0) begin errors++; $display("FAIL b2b_load_stall got %b want 0", StallM); end
    @(posedge clk); #1;
    checks++; if (ReadDataW !== 32'hA5A5_0001 || ALU_ResultW !== 32'h500 || RD_W !== 5'd3) begin errors++; $display("FAIL b2b_load got rdata=%h alu=%h rd=%0d", ReadDataW, ALU_ResultW, RD_W); end
    @(negedge clk);
    ResultSrcM = 0; ALU_ResultM = 32'h777; RD_M = 4;
    #1;
    checks++; if (StallM !== 1'b0 || mem_bus.mem_req !== 1'b0) begin errors++; $display("FAIL b2b_alu_req got stall=%b req=%b want 0 0", StallM, mem_bus.mem_req); end
    @(posedge clk); #1;
    checks++; if (ALU_ResultW !== 32'h777 || ReadDataW !== 32'h0 || RegWriteW !== 1'b1 || RD_W !== 5'd4 || ResultSrcW !== 1'b0) begin errors++; $display("FAIL b2b_alu got alu=%h rdata=%h rw=%b rd=%0d rs=%b", ALU_ResultW, ReadDataW, RegWriteW, RD_W, ResultSrcW); end
  endtask

  initial begin
    test_reset();
    test_zero_wait_load();
    test_store_wait();
    test_misaligned();
    test_timeout(32'h300, 5'd9);
    test_reset_mid_wait();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/memory_cycle.md
Name: memory_cycle

Overview:
- Fourth pipeline stage. Sits directly downstream of execute_cycle and consumes its M-side pipeline outputs.
- Performs load/store accesses to an external data memory over a valid/ready handshake with a timeout watchdog.
- Stalls the upstream pipeline while an access is outstanding.
- Registers the M/W pipeline register that feeds writeback.

Parameters:
- TIMEOUT_CYCLES, 255: maximum wait cycles per access before abort. Legal range 1..(2**CNT_W - 1).
- CNT_W, 8: width of the wait counter.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; asynchronous, active-low
- RegWriteM  in  1  register write enable from execute
- MemWriteM  in  1  store request
- ResultSrcM  in  1  1 = load (result from memory)
- RD_M  in  5  destination register
- PCPlus4M  in  32  PC+4
- WriteDataM  in  32  store data
- ALU_ResultM  in  32  effective address / ALU result
- mem_req  out  1  memory request valid
- mem_we  out  1  1 = write
- mem_addr  out  32  word-aligned byte address
- mem_wdata  out  32  store data
- mem_ready  in  1  memory accepts/completes the access this cycle
- mem_rdata  in  32  load data, valid when mem_ready=1 and mem_we=0
- StallM  out  1  to hazard unit; holds the F/D/E stages and the execute_cycle M register
- RegWriteW  out  1  registered
- ResultSrcW  out  1  registered
- RD_W  out  5  registered
- PCPlus4W  out  32  registered
- ALU_ResultW  out  32  registered
- ReadDataW  out  32  registered load data
- ErrW  out  1  registered one-cycle pulse: access aborted (misaligned or timeout)

Behaviour:
- access = MemWriteM | ResultSrcM. misaligned = access & (ALU_ResultM[1:0] != 0).
- FSM states:
  - IDLE: no access outstanding, counter = 0.
  - WAIT: request issued, mem_ready not yet seen.
- Request outputs (combinational):
  - mem_req = access & ~misaligned & ~timeout_hit.
  - mem_we = MemWriteM.
  - mem_addr = {ALU_ResultM[31:2], 2'b00}.
  - mem_wdata = WriteDataM.
  - Upstream holds the M inputs stable while StallM=1, so request fields stay constant across WAIT.
- Transitions:
  - IDLE -> WAIT when mem_req & ~mem_ready; counter <= 1.
  - IDLE stays IDLE on zero-wait completion (mem_req & mem_ready).
  - WAIT -> IDLE on mem_ready, or on timeout_hit (counter == TIMEOUT_CYCLES).
  - WAIT otherwise: counter increments, saturating at TIMEOUT_CYCLES.
- StallM = mem_req & ~mem_ready. Misaligned accesses never stall. On a timeout_hit cycle, mem_req and StallM deassert and the access completes as aborted.
- Completion cycle (~StallM): W register loads RegWriteM, ResultSrcM, RD_M, PCPlus4M, ALU_ResultM.
  - Load completed by mem_ready: ReadDataW <= mem_rdata.
  - Non-load: ReadDataW <= 0.
- Abort (misaligned or timeout):
  - RegWriteW <= 0; ErrW <= 1 for exactly one cycle; ReadDataW <= 0; other W fields captured normally.
  - An aborted store is never acknowledged; memory contents are unspecified by this block.
- Stall cycles: W register takes a bubble (RegWriteW <= 0, ErrW <= 0, ResultSrcW <= 0). Other W fields hold their values.
- Latency: zero-wait access completes in the same cycle (W valid next edge). N-wait access stalls N cycles.
- Reset (asynchronous, any time, including mid-WAIT):
  - state = IDLE, counter = 0.
  - All W outputs = 0 and ErrW = 0.
  - Combinational outputs follow their inputs.
  - No access is retried after reset.
- mem_ready with mem_req=0 is ignored. mem_rdata is sampled only on load completion.

Decomposition:
- Shared pipeline package:
  - FSM state encoding (IDLE=1'b0, WAIT=1'b1).
  - Word-alignment mask constant.
  - Default TIMEOUT_CYCLES.
- One natural sub-module: mem_wait_ctrl, containing the FSM, wait counter, timeout_hit, StallM and mem_req generation.
- The W pipeline register stays in memory_cycle.

Test Plan:
- Zero-wait load: ALU_ResultM=0x100, ResultSrcM=1, RegWriteM=1, RD_M=5, mem_ready=1, mem_rdata=0xDEADBEEF -> StallM never 1; next edge ReadDataW=0xDEADBEEF, RD_W=5, RegWriteW=1.
- 3-wait store: MemWriteM=1, addr 0x204, WriteDataM=0x12345678, mem_ready high on 4th cycle -> StallM=1 for 3 cycles with stable mem_addr/mem_wdata; RegWriteW=0 bubbles for 3 cycles, then W updates once.
- Misaligned load at 0x102 -> mem_req=0, StallM=0; next edge ErrW=1 for one cycle, RegWriteW=0, ReadDataW=0.
- Timeout with TIMEOUT_CYCLES=4, mem_ready held 0 -> StallM=1 for exactly 4 cycles; ErrW pulses once, RegWriteW=0, FSM returns to IDLE, next access proceeds normally.
- Reset asserted mid-WAIT (cycle 2 of stall) -> all W outputs 0 immediately; after release, FSM is IDLE with counter 0 and no residual ErrW.
- Back-to-back accesses (load then ALU op with access=0) -> ALU op passes through with no stall; ALU_ResultW and ReadDataW=0 are correct on consecutive edges.
